imem_loader: RTL

Program loader and instruction encoder for the Y86-64 pipeline: the write side of instruction memory, whose read side is the fetch stage. It accepts one decoded instruction per handshake as icode, ifun, rA, rB and valC. It serializes the instruction into the byte layout that fetch parses, writing one byte per cycle into instruction memory starting at an internal write pointer. It also reports a fetch-compatible status code.

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Y86-64 instruction encoder; serializes one decoded instruction
//               into instruction memory, one byte per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_pc,
  input  logic [63:0] set_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [3:0]  in_rA,
  input  logic [3:0]  in_rB,
  input  logic [63:0] in_valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [63:0] wr_ptr,
  output logic [2:0]  stat,
  output logic [31:0] instr_count
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  localparam logic [2:0]  C_SAOK      = 3'd1;
  localparam logic [2:0]  C_SADR      = 3'd2;
  localparam logic [2:0]  C_SINS      = 3'd3;
  localparam logic [64:0] C_MEM_LIMIT = 65'(MEM_SIZE);

  state_t      state_q, state_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic        nr_q, nr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [63:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] count_q, count_d;

  logic        w_nr;
  logic        w_nv;
  logic [3:0]  w_len;
  logic [64:0] w_end;
  logic [2:0]  w_vidx;
  logic [7:0]  w_byte;

  assign in_ready    = (state_q == S_IDLE) && !set_pc && !reset;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr      = wr_ptr_q;
  assign stat        = stat_q;
  assign instr_count = count_q;

  always_comb begin
    w_nr = 1'b0;
    w_nv = 1'b0;
    case (in_icode)
      4'd2, 4'd6, 4'd10, 4'd11: w_nr = 1'b1;
      4'd3, 4'd4, 4'd5: begin
        w_nr = 1'b1;
        w_nv = 1'b1;
      end
      4'd7, 4'd8: w_nv = 1'b1;
      default: ;
    endcase
  end

  assign w_len = 4'd1 + {3'b000, w_nr} + (w_nv ? 4'd8 : 4'd0);
  // 65-bit sum so a pointer near 2^64 cannot wrap past the bounds check
  assign w_end = {1'b0, wr_ptr_q} + {61'd0, w_len};

  // valC byte index relative to the current output byte; wraps mod 8 by design
  assign w_vidx = idx_q[2:0] - 3'd1 - {2'b00, nr_q};
  assign w_byte = (nr_q && idx_q == 4'd1) ? {ra_q, rb_q} : valc_q[{w_vidx, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    nr_d        = nr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    stat_d      = stat_q;
    count_d     = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (set_pc) begin
          wr_ptr_d = set_addr;
        end else if (in_valid) begin
          if (in_icode > 4'd11) begin
            stat_d = C_SINS;
          end else if (w_end > C_MEM_LIMIT) begin
            stat_d = C_SADR;
          end else begin
            stat_d      = C_SAOK;
            state_d     = S_EMIT;
            ra_d        = in_rA;
            rb_d        = in_rB;
            valc_d      = in_valC;
            nr_d        = w_nr;
            len_d       = w_len;
            idx_d       = 4'd1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = {in_icode, in_ifun};
          end
        end
      end
      S_EMIT: begin
        wr_ptr_d = wr_ptr_q + 64'd1;
        if (idx_q == len_q) begin
          state_d = S_IDLE;
          count_d = count_q + 32'd1;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q + 64'd1;
          mem_wdata_d = w_byte;
          idx_d       = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ra_q        <= 4'd0;
      rb_q        <= 4'd0;
      valc_q      <= 64'd0;
      nr_q        <= 1'b0;
      len_q       <= 4'd0;
      idx_q       <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 8'd0;
      wr_ptr_q    <= 64'd0;
      stat_q      <= C_SAOK;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      nr_q        <= nr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      stat_q      <= stat_d;
      count_q     <= count_d;
    end
  end

endmodule

`default_nettype wire
